// File: rtl/as_slave_bpi.sv
// Wishbone classic slave BPI: window decode, programmable wait states, one-cycle core strobe, registered read data.
// Latency: ack in cycle n+2+wait_states after stb is first sampled; one transfer per 3+wait_states cycles.
// Backpressure: none toward the core; the master is held off by withholding ack, and dropping cyc aborts the transfer.
//
// Ports:
//   clk_i, rst_i (async active-low)
//   wb_s_*  : Wishbone slave side (addr, dat in/out, we, sel, stb, cyc, ack)
//   core_*  : local side (offset addr, captured write data/sel, wr/rd strobes, combinational read data in)
module as_slave_bpi #(
  parameter int                    addr_width  = 64,
  parameter int                    data_width  = 64,
  parameter logic [addr_width-1:0] base_addr   = 64'h0000_0000_0000_1000,
  parameter logic [addr_width-1:0] addr_mask   = 64'h0000_0000_0000_0FFF,
  parameter int                    wait_states = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [addr_width-1:0]   wb_s_addr_i,
  input  logic [data_width-1:0]   wb_s_dat_i,
  output logic [data_width-1:0]   wb_s_dat_o,
  input  logic                    wb_s_we_i,
  input  logic [data_width/8-1:0] wb_s_sel_i,
  input  logic                    wb_s_stb_i,
  input  logic                    wb_s_cyc_i,
  output logic                    wb_s_ack_o,
  output logic [addr_width-1:0]   core_addr_o,
  output logic [data_width-1:0]   core_dat_o,
  output logic [data_width/8-1:0] core_sel_o,
  output logic                    core_wr_o,
  output logic                    core_rd_o,
  input  logic [data_width-1:0]   core_dat_i
);

  localparam int sel_width = data_width / 8;
  // Counter is loaded with wait_states-1 so that WAIT lasts exactly wait_states cycles.
  localparam logic [3:0] ws_load = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic [addr_width-1:0]  r_addr;
  logic [data_width-1:0]  r_dat;
  logic [sel_width-1:0]   r_sel;
  logic [data_width-1:0]  r_rdat;

  logic                   w_req;
  logic                   w_access;
  logic [data_width-1:0]  w_lane_mask;

  assign w_req    = wb_s_cyc_i & wb_s_stb_i & ((wb_s_addr_i & ~addr_mask) == base_addr);
  assign w_access = (r_state == S_ACCESS);

  // Unselected byte lanes of read data are returned as zero.
  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < sel_width; i++) begin
      w_lane_mask[i*8 +: 8] = {8{r_sel[i]}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (wait_states > 0) w_next = S_WAIT;
          else                 w_next = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!wb_s_cyc_i)        w_next = S_IDLE;
        else if (r_cnt == 4'd0) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = wb_s_cyc_i ? S_ACK : S_IDLE;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt  <= 4'd0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_rdat <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_cnt  <= ws_load;
        r_we   <= wb_s_we_i;
        r_addr <= wb_s_addr_i & addr_mask;
        r_dat  <= wb_s_dat_i;
        r_sel  <= wb_s_sel_i;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data is only sampled when the read strobe actually fired.
      if (w_access && !r_we && wb_s_cyc_i) begin
        r_rdat <= core_dat_i & w_lane_mask;
      end
    end
  end

  // Strobes and ack are decoded from the state register and qualified by the
  // live bus, so they drop the instant the master or reset withdraws.
  assign core_wr_o   = w_access &  r_we & wb_s_cyc_i;
  assign core_rd_o   = w_access & ~r_we & wb_s_cyc_i;
  assign wb_s_ack_o  = (r_state == S_ACK) & wb_s_cyc_i & wb_s_stb_i;
  assign wb_s_dat_o  = r_rdat;
  assign core_addr_o = r_addr;
  assign core_dat_o  = r_dat;
  assign core_sel_o  = r_sel;

endmodule

// File: tb/tb_as_slave_bpi.sv
// Testbench for as_slave_bpi: three instances with wait_states 0, 3 and 2.
// Directed vector table plus hand sequences for abort and async reset.
// Each instance has its own cyc/stb so idle instances stay quiet.
module tb_as_slave_bpi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] addr, wdat, cdat_in;
  logic [7:0]  sel;
  logic        we;
  logic        cyc_v [3];
  logic        stb_v [3];
  logic        ack_v [3];
  logic        wr_v  [3];
  logic        rd_v  [3];
  logic [63:0] rdat_v  [3];
  logic [63:0] caddr_v [3];
  logic [63:0] cdat_v  [3];
  logic [7:0]  csel_v  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  as_slave_bpi #(.wait_states(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst_n),
    .wb_s_addr_i(addr), .wb_s_dat_i(wdat), .wb_s_dat_o(rdat_v[0]),
    .wb_s_we_i(we), .wb_s_sel_i(sel), .wb_s_stb_i(stb_v[0]), .wb_s_cyc_i(cyc_v[0]),
    .wb_s_ack_o(ack_v[0]), .core_addr_o(caddr_v[0]), .core_dat_o(cdat_v[0]),
    .core_sel_o(csel_v[0]), .core_wr_o(wr_v[0]), .core_rd_o(rd_v[0]), .core_dat_i(cdat_in)
  );

  as_slave_bpi #(.wait_states(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst_n),
    .wb_s_addr_i(addr), .wb_s_dat_i(wdat), .wb_s_dat_o(rdat_v[1]),
    .wb_s_we_i(we), .wb_s_sel_i(sel), .wb_s_stb_i(stb_v[1]), .wb_s_cyc_i(cyc_v[1]),
    .wb_s_ack_o(ack_v[1]), .core_addr_o(caddr_v[1]), .core_dat_o(cdat_v[1]),
    .core_sel_o(csel_v[1]), .core_wr_o(wr_v[1]), .core_rd_o(rd_v[1]), .core_dat_i(cdat_in)
  );

  as_slave_bpi #(.wait_states(2)) u_ws2 (
    .clk_i(clk), .rst_i(rst_n),
    .wb_s_addr_i(addr), .wb_s_dat_i(wdat), .wb_s_dat_o(rdat_v[2]),
    .wb_s_we_i(we), .wb_s_sel_i(sel), .wb_s_stb_i(stb_v[2]), .wb_s_cyc_i(cyc_v[2]),
    .wb_s_ack_o(ack_v[2]), .core_addr_o(caddr_v[2]), .core_dat_o(cdat_v[2]),
    .core_sel_o(csel_v[2]), .core_wr_o(wr_v[2]), .core_rd_o(rd_v[2]), .core_dat_i(cdat_in)
  );

  typedef struct {
    int          dut;
    logic [63:0] addr;
    logic [63:0] dat;
    logic [7:0]  sel;
    logic        we;
    logic [63:0] cdat;
    logic        hit;
    int          st_cyc;
    int          ack_cyc;
    logic [63:0] caddr;
    logic [63:0] rdat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, " ack"},   64'(ack_v[d]), 64'd0);
    check({tag, " wr"},    64'(wr_v[d]),  64'd0);
    check({tag, " rd"},    64'(rd_v[d]),  64'd0);
    check({tag, " rdat"},  rdat_v[d],     64'd0);
    check({tag, " caddr"}, caddr_v[d],    64'd0);
    check({tag, " cdat"},  cdat_v[d],     64'd0);
    check({tag, " csel"},  64'(csel_v[d]), 64'd0);
  endtask

  // Called right after a falling edge; that cycle is cycle n. Cycle c is sampled
  // on the falling edge c cycles later. Bus inputs are scrambled after cycle 1
  // to show the transfer runs on captured values.
  task automatic run_txn(input string tag, input vec_t v, input int abort_at, input int ncyc);
    int          st_cyc, st_cnt, ack_cyc, ack_cnt;
    logic        st_wr;
    logic [63:0] got_caddr, got_cdat, got_rdat;
    logic [7:0]  got_csel;
    int          d;
    d = v.dut;
    st_cyc = -1; st_cnt = 0; ack_cyc = -1; ack_cnt = 0; st_wr = 1'b0;
    got_caddr = '0; got_cdat = '0; got_rdat = '0; got_csel = '0;
    addr = v.addr; wdat = v.dat; sel = v.sel; we = v.we; cdat_in = v.cdat;
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (wr_v[d] || rd_v[d]) begin
        st_cnt++;
        if (st_cyc < 0) begin
          st_cyc = c; st_wr = wr_v[d];
          got_caddr = caddr_v[d]; got_cdat = cdat_v[d]; got_csel = csel_v[d];
        end
      end
      if (ack_v[d]) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = c; got_rdat = rdat_v[d];
        end
        cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
      end
      if (c == 1 && v.hit) begin
        addr = 64'h1FF0; wdat = ~v.dat; sel = ~v.sel; we = ~v.we;
      end
      if (c == abort_at) begin
        cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
      end
    end
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
    if (v.hit) begin
      check({tag, " strobe_cycle"}, 64'(st_cyc), 64'(v.st_cyc));
      check({tag, " strobe_is_wr"}, 64'(st_wr), 64'(v.we));
      check({tag, " strobe_width"}, 64'(st_cnt), 64'd1);
      check({tag, " core_addr"}, got_caddr, v.caddr);
      check({tag, " core_dat"}, got_cdat, v.dat);
      check({tag, " core_sel"}, 64'(got_csel), 64'(v.sel));
      check({tag, " ack_cycle"}, 64'(ack_cyc), 64'(v.ack_cyc));
      check({tag, " ack_count"}, 64'(ack_cnt), 64'd1);
      check({tag, " rdat"}, got_rdat, v.rdat);
    end else begin
      check({tag, " no_strobe"}, 64'(st_cnt), 64'd0);
      check({tag, " no_ack"}, 64'(ack_cnt), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          dut addr           dat                    sel    we    cdat                   hit  st ack caddr        rdat
    vecs[0] = '{0, 64'h1008, 64'hA5A5_0000_1234_5678, 8'hFF, 1'b1, 64'h0,                 1'b1, 1, 2, 64'h008, 64'h0};
    vecs[1] = '{1, 64'h1010, 64'h0000_0000_0000_0BAD, 8'hFF, 1'b0, 64'h1122_3344_5566_7788, 1'b1, 4, 5, 64'h010, 64'h1122_3344_5566_7788};
    vecs[2] = '{1, 64'h1018, 64'h0000_0000_0000_0C0D, 8'h0F, 1'b0, 64'h1122_3344_5566_7788, 1'b1, 4, 5, 64'h018, 64'h0000_0000_5566_7788};
    vecs[3] = '{0, 64'h1FF8, 64'h0000_0000_0000_0001, 8'hF0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 2, 64'hFF8, 64'hDEAD_BEEF_0000_0000};
    vecs[4] = '{0, 64'h1100, 64'h0000_0000_0000_0077, 8'h01, 1'b1, 64'h0,                 1'b1, 1, 2, 64'h100, 64'hDEAD_BEEF_0000_0000};
    vecs[5] = '{2, 64'h1000, 64'h0000_0000_0000_5555, 8'h00, 1'b1, 64'h0,                 1'b1, 3, 4, 64'h000, 64'h0};
    vecs[6] = '{0, 64'h2000, 64'h0000_0000_0000_1111, 8'hFF, 1'b1, 64'h0,                 1'b0, 0, 0, 64'h0,   64'h0};
    vecs[7] = '{1, 64'h0FF8, 64'h0000_0000_0000_2222, 8'hFF, 1'b0, 64'h0,                 1'b0, 0, 0, 64'h0,   64'h0};
    vecs[8] = '{2, 64'h1FFF, 64'h0000_0000_0000_3333, 8'h3C, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 3, 4, 64'hFFF, 64'h0000_4567_89AB_0000};

    rst_n = 1'b0;
    addr = '0; wdat = '0; sel = '0; we = 1'b0; cdat_in = '0;
    for (int i = 0; i < 3; i++) begin
      cyc_v[i] = 1'b0; stb_v[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle_outputs($sformatf("reset d%0d", i), i);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i], 0, 12);
      @(negedge clk);
    end

    // Abort: cyc dropped in the second WAIT cycle, then a new request one cycle later.
    v = '{2, 64'h1040, 64'h0000_0000_0000_4444, 8'hFF, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 0, 0, 64'h0, 64'h0};
    run_txn("abort", v, 2, 3);
    v = '{2, 64'h1020, 64'h0000_0000_0000_6666, 8'hFF, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 3, 4, 64'h020, 64'h0F0F_0F0F_0F0F_0F0F};
    run_txn("after_abort", v, 0, 12);
    @(negedge clk);

    // Asynchronous reset between edges while in ACCESS.
    addr = 64'h1020; wdat = 64'h9999; sel = 8'hFF; we = 1'b1;
    cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid wr_before", 64'(wr_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid d0", 0);
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{0, 64'h1000, 64'h0000_0000_ABCD_0000, 8'hFF, 1'b1, 64'h0, 1'b1, 1, 2, 64'h000, 64'h0};
    run_txn("post_reset", v, 0, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/as_slave_bpi.md
Name: as_slave_bpi

Overview:
- Wishbone classic slave bus-protocol interface. It is the downstream counterpart of the core's Wishbone master BPI.
- It decodes a configurable address window and adds programmable wait states.
- It turns one Wishbone cycle into a single-cycle access strobe toward a local peripheral or memory core, then returns registered read data with ack.
- It sits between the bus interconnect and each peripheral (RAM, GPIO, UART register banks).

Parameters:
- base_addr, 64'h0000_0000_0000_1000, window base. Must be aligned to the window size.
- addr_mask, 64'h0000_0000_0000_0FFF, local offset bits. The window is (addr & ~addr_mask) == base_addr.
- addr_width, 64, Wishbone address width.
- data_width, 64, data width. Must be a multiple of 8; sel width is data_width/8.
- wait_states, 0, extra cycles inserted before the core access (0..15).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-low.
- wb_s_addr_i  in  addr_width  bus address.
- wb_s_dat_i  in  data_width  write data from the master.
- wb_s_dat_o  out  data_width  read data to the master.
- wb_s_we_i  in  1  write enable.
- wb_s_sel_i  in  data_width/8  byte lane select.
- wb_s_stb_i  in  1  valid cycle.
- wb_s_cyc_i  in  1  bus cycle active.
- wb_s_ack_o  out  1  transfer acknowledge.
- core_addr_o  out  addr_width  local offset (addr & addr_mask).
- core_dat_o  out  data_width  captured write data.
- core_sel_o  out  data_width/8  captured byte selects.
- core_wr_o  out  1  one-cycle write strobe.
- core_rd_o  out  1  one-cycle read strobe.
- core_dat_i  in  data_width  read data from the core, valid combinationally during core_rd_o.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State is IDLE, wait counter is 0.
  - wb_s_dat_o, core_addr_o, core_dat_o, core_sel_o are 0.
  - wb_s_ack_o, core_wr_o, core_rd_o are 0.
  - Release is synchronous to clk_i.
- Request: cyc_i & stb_i & window match.
- IDLE:
  - On a request at a rising edge, capture local offset, dat, sel and we into holding registers.
  - Go to WAIT if wait_states>0 (counter loaded with wait_states-1), else go to ACCESS.
  - Addresses outside the window are ignored: stay IDLE, never ack.
- WAIT:
  - Decrement the counter each cycle; go to ACCESS when it is 0.
  - If cyc_i=0 in any WAIT cycle, abort to IDLE. No core strobe, no ack.
- ACCESS (exactly 1 cycle):
  - core_wr_o = captured we & cyc_i; core_rd_o = ~captured we & cyc_i.
  - On a read, at the end of the cycle wb_s_dat_o <= core_dat_i with each unselected byte lane forced to 0. On a write, wb_s_dat_o is unchanged.
  - If cyc_i=0, no strobe; go to IDLE.
  - Otherwise go to ACK.
- ACK (exactly 1 cycle):
  - wb_s_ack_o = cyc_i & stb_i. This term is combinational from the state register, so ack never appears without a live strobe.
  - Always go to IDLE next cycle.
- Latency: stb first sampled high in cycle n; ack asserted in cycle n+2+wait_states. Throughput is one transfer per 3+wait_states cycles.
- Back-to-back:
  - A request present in the cycle after ACK is captured as a new transfer.
  - A master holding stb high across ack therefore issues a second transfer. This is intended.
- Capture rules:
  - Bus inputs that change after capture have no effect on the current transfer; core outputs use the captured values.
- Strobes and holding registers:
  - core_wr_o and core_rd_o are mutually exclusive and never high outside ACCESS.
  - core_addr_o, core_dat_o and core_sel_o hold their captured values until the next capture.
- sel=0 on a write still produces a core_wr_o pulse with sel 0; the core must ignore it.
- Reset mid-transfer returns to IDLE immediately with all strobes and ack low; the in-flight transfer is lost.

Test Plan:
- Write, wait_states=0: addr 0x1008, dat 0xA5A5_0000_1234_5678, sel 0xFF, we=1.
  - core_wr_o pulses in cycle n+1 with core_addr_o=0x008 and that data.
  - Ack in cycle n+2 for exactly 1 cycle.
- Read, wait_states=3: addr 0x1010, core_dat_i=0x1122_3344_5566_7788.
  - core_rd_o pulses in cycle n+4; ack in cycle n+5.
  - wb_s_dat_o=0x1122_3344_5566_7788 while ack=1.
- Partial read, sel=0x0F:
  - wb_s_dat_o=0x0000_0000_5566_7788; core_sel_o=0x0F.
- Out of window: addr 0x2000, stb held 10 cycles.
  - No core strobe, no ack; state stays IDLE.
- Abort, wait_states=2: cyc_i dropped in the second WAIT cycle.
  - No core strobe, no ack.
  - A new request 1 cycle later completes normally.
- Async reset asserted during ACCESS between edges:
  - core_wr_o/core_rd_o and ack fall immediately, all outputs read 0.
  - After release a fresh write to 0x1000 completes with ack at n+2.
